// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI-mode command sequencer: CS, dummy byte, 6 command bytes, R1 with timeout, optional R1b busy poll, trailer.
// Optional SD_CRC7_EN: byte5 is generated internally as {crc7, 1} instead of taken from cmd_crc.
module sd_cmd_sequencer #(
  parameter int unsigned RESP_TIMEOUT = 4096,
  parameter int unsigned BUSY_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk_posedge,
  input  logic        cmd_valid,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [7:0]  cmd_crc,
  input  logic        cmd_busy,
  output logic        cmd_ready,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic        resp_timeout,
  output logic        cs_n,
  input  logic        miso,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        rx_en,
  output logic        rx_reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done
);

  localparam int unsigned RT_W = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned BT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, PRE, SEND, RESP, BUSY, FIN} state_t;

  state_t          state;
  logic [5:0]      idx_q;
  logic [31:0]     arg_q;
  logic            busy_q;
  logic [2:0]      byte_cnt;
  logic            pend;
  logic [1:0]      skip;
  logic [RT_W-1:0] timer;
  logic [BT_W-1:0] busy_cnt;
  logic [7:0]      byte5;
  logic [7:0]      cmd_byte;
  logic            tx_ok;
  logic            rx_ok;
  logic            crc_done;

`ifdef SD_CRC7_EN
  logic [39:0] crc_sh;
  logic [6:0]  crc7;
  logic [5:0]  crc_bits;
  assign byte5    = {crc7, 1'b1};
  assign crc_done = (crc_bits == 6'd40);
`else
  logic [7:0] crc_q;
  assign byte5    = crc_q;
  assign crc_done = 1'b1;
`endif

  // skip masks the stale *_done level during the enable pulse and the cycle after it
  assign tx_ok = pend && (skip == 2'd0) && tx_done;
  assign rx_ok = (skip == 2'd0) && rx_done;

  always_comb begin
    cmd_byte = 8'hFF;
    case (byte_cnt)
      3'd0:    cmd_byte = {2'b01, idx_q};
      3'd1:    cmd_byte = arg_q[31:24];
      3'd2:    cmd_byte = arg_q[23:16];
      3'd3:    cmd_byte = arg_q[15:8];
      3'd4:    cmd_byte = arg_q[7:0];
      3'd5:    cmd_byte = byte5;
      default: cmd_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cs_n         <= 1'b1;
      cmd_ready    <= 1'b1;
      tx_en        <= 1'b0;
      rx_en        <= 1'b0;
      rx_reset     <= 1'b0;
      resp_valid   <= 1'b0;
      resp_r1      <= 8'hFF;
      resp_timeout <= 1'b0;
      tx_data      <= 8'hFF;
      idx_q        <= '0;
      arg_q        <= '0;
      busy_q       <= 1'b0;
      byte_cnt     <= '0;
      pend         <= 1'b0;
      skip         <= '0;
      timer        <= '0;
      busy_cnt     <= '0;
`ifdef SD_CRC7_EN
      crc_sh       <= '0;
      crc7         <= '0;
      crc_bits     <= '0;
`else
      crc_q        <= '0;
`endif
    end else begin
      tx_en      <= 1'b0;
      rx_en      <= 1'b0;
      rx_reset   <= 1'b0;
      resp_valid <= 1'b0;
      if (skip != 2'd0) skip <= skip - 2'd1;

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            idx_q        <= cmd_index;
            arg_q        <= cmd_arg;
            busy_q       <= cmd_busy;
            cs_n         <= 1'b0;
            cmd_ready    <= 1'b0;
            resp_timeout <= 1'b0;
            pend         <= 1'b0;
`ifdef SD_CRC7_EN
            crc_sh       <= {2'b01, cmd_index, cmd_arg};
            crc7         <= '0;
            crc_bits     <= '0;
`else
            crc_q        <= cmd_crc;
`endif
            state        <= PRE;
          end
        end

        PRE: begin
`ifdef SD_CRC7_EN
          if (!crc_done) begin
            crc7     <= {crc7[5:0], 1'b0} ^ ({7{crc_sh[39] ^ crc7[6]}} & 7'h09);
            crc_sh   <= {crc_sh[38:0], 1'b0};
            crc_bits <= crc_bits + 6'd1;
          end
`endif
          if (!pend) begin
            tx_en   <= 1'b1;
            tx_data <= 8'hFF;
            pend    <= 1'b1;
            skip    <= 2'd2;
          end else if (tx_ok && crc_done) begin
            pend     <= 1'b0;
            byte_cnt <= '0;
            state    <= SEND;
          end
        end

        SEND: begin
          if (!pend) begin
            tx_en   <= 1'b1;
            tx_data <= cmd_byte;
            pend    <= 1'b1;
            skip    <= 2'd2;
          end else if (tx_ok) begin
            pend <= 1'b0;
            if (byte_cnt == 3'd5) begin
              rx_en <= 1'b1;
              skip  <= 2'd2;
              timer <= '0;
              state <= RESP;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end

        RESP: begin
          if (rx_ok) begin
            resp_r1 <= rx_data;
            if (busy_q && !rx_data[7]) begin
              busy_cnt <= '0;
              state    <= BUSY;
            end else begin
              state <= FIN;
            end
          end else if (timer == RT_W'(RESP_TIMEOUT - 1)) begin
            rx_reset     <= 1'b1;
            resp_r1      <= 8'hFF;
            resp_timeout <= 1'b1;
            state        <= FIN;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end

        BUSY: begin
          if (sclk_posedge) begin
            if (miso) begin
              state <= FIN;
            end else if (busy_cnt == BT_W'(BUSY_TIMEOUT - 1)) begin
              resp_timeout <= 1'b1;
              state        <= FIN;
            end else begin
              busy_cnt <= busy_cnt + 1'b1;
            end
          end
        end

        FIN: begin
          if (!pend) begin
            cs_n    <= 1'b1;
            tx_en   <= 1'b1;
            tx_data <= 8'hFF;
            pend    <= 1'b1;
            skip    <= 2'd2;
          end else if (tx_ok) begin
            pend       <= 1'b0;
            resp_valid <= 1'b1;
            cmd_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
